fetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the decoder.
- Owns the fetch PC and drives the address of the combinational instruction memory.
- Buffers fetched {pc, inst} pairs in a small FIFO and hands them to decode over a valid/ready handshake, so decode stalls no longer need the global enable counter.
- Accepts branch/jump redirects from execute, which flush the buffer.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/sync_fifo.sv | 71 +++++++
 rtl/fetch_queue.sv | 107 ++++++++++
 tb/tb_fetch_queue.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   XLEN / ILEN    : address and instruction widths
//   INST_NOP       : canonical NOP (addi x0, x0, 0) shown when no entry is valid
//   RESET_PC       : default fetch address after reset
//   fetch_entry_t  : one buffered {pc, inst} pair
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC = 64'h0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   flush          : empty the FIFO (pointers and count to zero)
//   push / wdata   : write request; accepted when not full, or when full with a pop
//   pop            : read request; ignored when empty
//   rdata          : head entry (valid only when !empty)
//   full / empty   : status
//   count          : occupancy, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];

    assign do_pop  = pop && !empty;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, addresses the combinational
// instruction memory, buffers {pc, inst} pairs and hands them to decode over
// valid/ready. Redirects from execute flush the buffer and retarget fetch.
// Optional build macro FETCH_QUEUE_BYPASS_EN: when the buffer is empty the
// memory output is presented to decode combinationally, saving one cycle.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   redirect_valid, redirect_pc : PC change request (low two bits dropped)
//   imem_addr, imem_inst        : instruction memory address / data
//   out_valid, out_ready        : decode handshake
//   out_inst, out_pc, out_pc4   : head entry and its link address
//   count                       : buffer occupancy (debug)
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic [XLEN-1:0]         imem_addr,
    input  logic [ILEN-1:0]         imem_inst,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ILEN-1:0]         out_inst,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_pc4,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = XLEN + ILEN;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] redirect_tgt;
    logic [EW-1:0]   head;
    logic [XLEN-1:0] head_pc;
    logic [ILEN-1:0] head_inst;
    logic            fifo_full, fifo_empty;
    logic            fifo_push, fifo_pop;
    logic            fetch_adv, bypass_take;
    logic [CW-1:0]   fifo_count;

    assign redirect_tgt = redirect_pc & ~XLEN'(3);
    assign head_pc      = head[EW-1:ILEN];
    assign head_inst    = head[ILEN-1:0];
    assign imem_addr    = fetch_pc_q;
    assign count        = fifo_count;
    assign out_pc4      = out_pc + XLEN'(4);

    always_comb begin
        out_valid   = !fifo_empty;
        out_inst    = fifo_empty ? INST_NOP : head_inst;
        out_pc      = fifo_empty ? '0 : head_pc;
        bypass_take = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        // Empty buffer: present the memory word directly. If decode takes it,
        // it never enters storage but the fetch PC still moves on.
        if (fifo_empty && !rst && !redirect_valid) begin
            out_valid   = 1'b1;
            out_inst    = imem_inst;
            out_pc      = fetch_pc_q;
            bypass_take = out_ready;
        end
`endif
        fifo_pop  = out_valid && out_ready && !fifo_empty;
        fetch_adv = !rst && !redirect_valid && (!fifo_full || fifo_pop);
        fifo_push = fetch_adv && !bypass_take;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (rst) begin
            fetch_pc_d = RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
        end else if (fetch_adv) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        fetch_pc_q <= fetch_pc_d;
    end

    // A pop coinciding with a redirect is still consumed by decode; the flush
    // discards whatever remains.
    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (fifo_push),
        .wdata ({fetch_pc_q, imem_inst}),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] imem_addr;
    logic [31:0] imem_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic [63:0] out_pc4;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory model: instruction word equals its address.
    assign imem_inst = imem_addr[31:0];

    fetch_queue #(.DEPTH(4), .XLEN(64), .RESET_PC(64'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_pc4        (out_pc4),
        .count          (count)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        out_ready      = 1'b0;
        @(negedge clk);
        step(2);

        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_inst", 64'(out_inst), 64'h13);
        check("rst_pc", out_pc, 64'h0);
        check("rst_addr", imem_addr, 64'h0);

        // Hold decode off for 10 cycles after reset release.
        rst = 1'b0;
        check("release_valid_same_cycle", 64'(out_valid), 64'd0);
        step(1);
        check("release_valid_next", 64'(out_valid), 64'd1);
        check("release_pc", out_pc, 64'h0);
        check("release_pc4", out_pc4, 64'h4);
        check("release_count", 64'(count), 64'd1);
        step(3);
        check("fill_count", 64'(count), 64'd4);
        check("fill_addr", imem_addr, 64'h10);
        step(6);
        check("full_hold_count", 64'(count), 64'd4);
        check("full_hold_addr", imem_addr, 64'h10);

        // Drain with decode always ready: continuous PC stream, no gap.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", 64'(out_valid), 64'd1);
            check("drain_pc", out_pc, 64'(4 * i));
            check("drain_pc4", out_pc4, 64'(4 * i + 4));
            check("drain_inst", 64'(out_inst), 64'(4 * i));
            step(1);
            if (i == 0) check("full_pop_push_count", 64'(count), 64'd4);
        end

        // Reset while streaming.
        rst = 1'b1;
        step(1);
        check("rst2_count", 64'(count), 64'd0);
        check("rst2_valid", 64'(out_valid), 64'd0);
        check("rst2_inst", 64'(out_inst), 64'h13);
        check("rst2_addr", imem_addr, 64'h0);

        rst = 1'b0;
        out_ready = 1'b0;
        step(2);
        check("pre_mid_rst_count", 64'(count), 64'd2);
        check("pre_mid_rst_addr", imem_addr, 64'h8);

        // Reset mid-stream with two entries held.
        rst = 1'b1;
        step(1);
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_addr", imem_addr, 64'h0);
        rst = 1'b0;
        step(1);
        check("restart_pc", out_pc, 64'h0);
        check("restart_count", 64'(count), 64'd1);
        step(2);
        check("pre_redirect_count", 64'(count), 64'd3);

        // Redirect with a pop in the same cycle; low bits of target dropped.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1002;
        out_ready      = 1'b1;
        check("redirect_pop_valid", 64'(out_valid), 64'd1);
        step(1);
        redirect_valid = 1'b0;
        check("redirect_flush_valid", 64'(out_valid), 64'd0);
        check("redirect_flush_count", 64'(count), 64'd0);
        check("redirect_addr", imem_addr, 64'h1000);
        step(1);
        check("redirect_tgt_valid", 64'(out_valid), 64'd1);
        check("redirect_tgt_pc", out_pc, 64'h1000);
        check("redirect_tgt_pc4", out_pc4, 64'h1004);
        check("redirect_tgt_inst", 64'(out_inst), 64'h1000);
        step(1);
        check("redirect_next_pc", out_pc, 64'h1004);

        // Redirect to the top of the address space and wrap.
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step(1);
        redirect_valid = 1'b0;
        check("top_flush_valid", 64'(out_valid), 64'd0);
        check("top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1);
        check("top_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("top_pc4_wrap", out_pc4, 64'h0);
        check("top_inst", 64'(out_inst), 64'hFFFF_FFFC);
        step(1);
        check("wrap_pc", out_pc, 64'h0);
        check("wrap_inst", 64'(out_inst), 64'h0);
        check("wrap_valid", 64'(out_valid), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
